// File: rtl/i2c_write_master.sv
// I2C write-only master. It sends START, {address,W}, sub-address, data0, data1
// and STOP, and aborts to STOP on a NAK. The outputs are open-drain enables:
// *_oe=1 pulls the line low and *_oe=0 releases it to the pull-up. Each bus bit
// spans four quarter periods of CLK_DIV clocks. A slave holding SCL low stretches
// the current quarter.
module i2c_write_master #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] i2c_addr,
    input  logic [7:0] sub_addr,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic       done,
    output logic       nak
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] state, state_n;
    logic [1:0] quarter, quarter_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [1:0] byte_idx, byte_idx_n;
    logic [7:0] shift, shift_n;
    logic [7:0] sub_q, data0_q, data1_q;
    logic [7:0] next_byte;
    logic [7:0] div_cnt;
    logic       nak_n, done_n, sda_oe_n, scl_oe_n;
    logic       accept, stretch, tick;

    // A start that coincides with the done pulse is deliberately not taken.
    assign accept  = (state == ST_IDLE) && start && !done;
    assign stretch = !scl_oe && !scl_in;
    assign tick    = (state != ST_IDLE) && !stretch && (div_cnt == DIV_LAST);

    // Select the byte that follows the current one.
    always_comb begin
        case (byte_idx)
            2'd0:    next_byte = sub_q;
            2'd1:    next_byte = data0_q;
            default: next_byte = data1_q;
        endcase
    end

    // Next-state sequencing, with line drive decoded from the next state.
    always_comb begin
        state_n    = state;
        quarter_n  = quarter;
        bit_cnt_n  = bit_cnt;
        byte_idx_n = byte_idx;
        shift_n    = shift;
        nak_n      = nak;
        done_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n    = ST_START;
                    quarter_n  = 2'd0;
                    bit_cnt_n  = 3'd0;
                    byte_idx_n = 2'd0;
                    shift_n    = {i2c_addr, 1'b0};
                    nak_n      = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (quarter == 2'd1) begin
                        state_n   = ST_BIT;
                        quarter_n = 2'd0;
                    end else begin
                        quarter_n = quarter + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    if (quarter == 2'd3) begin
                        quarter_n = 2'd0;
                        shift_n   = {shift[6:0], 1'b0};
                        if (bit_cnt == 3'd7) begin
                            state_n   = ST_ACK;
                            bit_cnt_n = 3'd0;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end else begin
                        quarter_n = quarter + 2'd1;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    if (quarter == 2'd2 && sda_in) begin
                        nak_n = 1'b1;
                    end
                    if (quarter == 2'd3) begin
                        quarter_n = 2'd0;
                        // nak was registered at the q2 tick, so it is valid here.
                        if (nak || byte_idx == 2'd3) begin
                            state_n = ST_STOP;
                        end else begin
                            state_n    = ST_BIT;
                            byte_idx_n = byte_idx + 2'd1;
                            shift_n    = next_byte;
                        end
                    end else begin
                        quarter_n = quarter + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (quarter == 2'd2) begin
                        state_n   = ST_IDLE;
                        quarter_n = 2'd0;
                        done_n    = 1'b1;
                    end else begin
                        quarter_n = quarter + 2'd1;
                    end
                end
            end
            default: begin
                state_n   = ST_IDLE;
                quarter_n = 2'd0;
            end
        endcase

        sda_oe_n = 1'b0;
        scl_oe_n = 1'b0;
        case (state_n)
            ST_START: sda_oe_n = (quarter_n == 2'd1);
            ST_BIT: begin
                scl_oe_n = !quarter_n[1];
                sda_oe_n = !shift_n[7];
            end
            ST_ACK:   scl_oe_n = !quarter_n[1];
            ST_STOP: begin
                sda_oe_n = (quarter_n != 2'd2);
                scl_oe_n = (quarter_n == 2'd0);
            end
            default: begin
                sda_oe_n = 1'b0;
                scl_oe_n = 1'b0;
            end
        endcase
    end

    // Quarter-period divider. It is held at zero in idle and frozen while the slave stretches SCL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == ST_IDLE || tick) begin
            div_cnt <= '0;
        end else if (!stretch) begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Capture the payload bytes when a transaction is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else if (accept) begin
            sub_q   <= sub_addr;
            data0_q <= data0;
            data1_q <= data1;
        end
    end

    // Register the FSM state and all outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            quarter  <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            nak      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            sda_oe   <= 1'b0;
            scl_oe   <= 1'b0;
        end else begin
            state    <= state_n;
            quarter  <= quarter_n;
            bit_cnt  <= bit_cnt_n;
            byte_idx <= byte_idx_n;
            shift    <= shift_n;
            nak      <= nak_n;
            done     <= done_n;
            busy     <= (state_n != ST_IDLE);
            sda_oe   <= sda_oe_n;
            scl_oe   <= scl_oe_n;
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Testbench for i2c_write_master with CLK_DIV=4. It contains a slave and bus model
// that ACKs, stretches SCL and decodes bytes. Table vectors cover full, stretched,
// NAK and re-pulsed transactions. Hand sequences cover start during the done cycle
// and reset in the middle of a transfer.
module tb_i2c_write_master;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [6:0] i2c_addr;
    logic [7:0] sub_addr, data0, data1;
    logic       sda_in, scl_in;
    logic       sda_oe, scl_oe, busy, done, nak;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2c_write_master #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .i2c_addr(i2c_addr), .sub_addr(sub_addr), .data0(data0), .data1(data1),
        .sda_in(sda_in), .scl_in(scl_in),
        .sda_oe(sda_oe), .scl_oe(scl_oe), .busy(busy), .done(done), .nak(nak)
    );

    // Slave and bus model
    logic        ack_en = 1'b0;
    logic        stretch_en = 1'b0;
    logic        slave_pull;
    int unsigned hold_left = 0;
    int          prev_slot = 0;

    // Bus monitor state. It is written only by the negedge monitor.
    logic        p_sda = 1'b0, p_scl = 1'b0, p_rst = 1'b0;
    int          slot = 0, starts = 0, stops = 0, dones = 0;
    logic [7:0]  sh = '0;
    logic [7:0]  bytes_q[$];

    assign slave_pull = ack_en && (slot > 0) && ((slot - 1) % 9 == 8);
    assign sda_in     = ~sda_oe & ~slave_pull;
    assign scl_in     = ~scl_oe & (hold_left == 0);

    // Hold SCL low for 50 released cycles during data0 bit 3 (slot index 21).
    always @(posedge clk) begin
        if (hold_left != 0 && !scl_oe)
            hold_left <= hold_left - 1;
        else if (stretch_en && slot == 22 && prev_slot != 22)
            hold_left <= 50;
        prev_slot <= slot;
    end

    // Decode the bus. An SDA change while SCL stays released is a START (fall) or a STOP (rise).
    always @(negedge clk) begin
        if (rst_n && p_rst) begin
            if (!p_scl && !scl_oe && (p_sda != sda_oe)) begin
                if (sda_oe) begin
                    starts++;
                    slot = 0;
                end else begin
                    stops++;
                end
            end
            if (!p_scl && scl_oe) slot++;
            if (p_scl && !scl_oe && slot > 0 && ((slot - 1) % 9 != 8)) begin
                sh = {sh[6:0], sda_in};
                if ((slot - 1) % 9 == 7) bytes_q.push_back(sh);
            end
            if (done) dones++;
        end
        p_sda = sda_oe;
        p_scl = scl_oe;
        p_rst = rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for done with a bounded cycle budget. n=1 is the first cycle after the accept edge.
    task automatic wait_done(input bit repulse, output int unsigned n, output bit seen);
        n = 1;
        seen = 1'b0;
        while (!seen && n < 4000) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                n++;
                start = repulse && (n == 10);
            end
        end
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  sub, d0, d1;
        bit          ack, str, repulse;
        int          nbytes;
        logic [31:0] eb;
        int unsigned lat;
        bit          exp_nak;
    } vec_t;

    task automatic run_vec(input string tag, input vec_t v);
        int          b0, st0, sp0, dn0;
        int unsigned n;
        bit          seen;
        logic [31:0] eb;
        b0  = bytes_q.size();
        st0 = starts;
        sp0 = stops;
        dn0 = dones;
        ack_en = v.ack;
        stretch_en = v.str;
        i2c_addr = v.addr;
        sub_addr = v.sub;
        data0 = v.d0;
        data1 = v.d1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
        chk({tag, "_nak_cleared"}, 32'(nak), 32'd0);
        wait_done(v.repulse, n, seen);
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, n, v.lat);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_nak"}, 32'(nak), 32'(v.exp_nak));
        @(negedge clk); #1;
        chk({tag, "_start_count"}, 32'(starts - st0), 32'd1);
        chk({tag, "_stop_count"}, 32'(stops - sp0), 32'd1);
        chk({tag, "_done_count"}, 32'(dones - dn0), 32'd1);
        chk({tag, "_byte_count"}, 32'(bytes_q.size() - b0), 32'(v.nbytes));
        chk({tag, "_slot_count"}, 32'(slot), 32'(9 * v.nbytes + 1));
        eb = v.eb;
        for (int i = 0; i < v.nbytes; i++) begin
            if (b0 + i < bytes_q.size())
                chk({tag, "_byte"}, 32'(bytes_q[b0 + i]), 32'(eb[31 - 8 * i -: 8]));
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    vec_t        vecs[5];
    int unsigned n;
    bit          seen;
    int          done_cnt;
    int          busy_cnt;

    initial begin
        // addr, sub, d0, d1, ack, stretch, repulse, nbytes, bytes, latency, nak
        vecs[0] = '{7'h70, 8'h0A, 8'h55, 8'h1F, 1, 0, 0, 4, 32'hE00A551F, 597, 0};
        vecs[1] = '{7'h70, 8'h7F, 8'hFA, 8'h4D, 1, 1, 0, 4, 32'hE07FFA4D, 647, 0};
        vecs[2] = '{7'h70, 8'h0A, 8'h55, 8'h1F, 0, 0, 0, 1, 32'hE0000000, 165, 1};
        vecs[3] = '{7'h3B, 8'h00, 8'hFF, 8'h80, 1, 0, 1, 4, 32'h7600FF80, 597, 0};
        vecs[4] = '{7'h7F, 8'hFF, 8'h00, 8'h01, 1, 0, 0, 4, 32'hFEFF0001, 597, 0};

        rst_n = 1'b0;
        start = 1'b0;
        i2c_addr = '0;
        sub_addr = '0;
        data0 = '0;
        data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_nak", 32'(nak), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) run_vec($sformatf("vec%0d", v), vecs[v]);

        // Hold start through the done cycle. It must be ignored there and taken one cycle later.
        ack_en = 1'b1;
        stretch_en = 1'b0;
        i2c_addr = 7'h70;
        sub_addr = 8'h0A;
        data0 = 8'h55;
        data1 = 8'h1F;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, n, seen);
        chk("seqA_first_done", 32'(seen), 32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        chk("seqA_start_in_done_ignored", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("seqA_start_next_cycle_taken", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(1'b0, n, seen);
        chk("seqA_second_latency", n, 32'd597);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-transfer: the transfer is abandoned with no done pulse.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (199) @(posedge clk);
        #1;
        chk("seqB_busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("seqB_rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("seqB_rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("seqB_rst_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        chk("seqB_no_done_after_reset", 32'(done_cnt), 32'd0);
        chk("seqB_idle_after_reset", 32'(busy_cnt), 32'd0);
        run_vec("seqB_fresh", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
